// File: rtl/rx_tile_scheduler_pkg.sv
// Shared types for the RX tile scheduler: bank lifecycle, launcher states, defaults.
package rx_tile_scheduler_pkg;

  localparam int TILE_W_DEF  = 288;
  localparam int FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    BANK_FREE      = 2'd0,
    BANK_FILLING   = 2'd1,
    BANK_READY     = 2'd2,
    BANK_COMPUTING = 2'd3
  } bank_state_e;

  typedef enum logic [1:0] {
    LNC_IDLE  = 2'd0,
    LNC_START = 2'd1,
    LNC_WAIT  = 2'd2
  } lnc_state_e;

  function automatic logic bank_is_writable(bank_state_e s);
    return (s == BANK_FREE) || (s == BANK_FILLING);
  endfunction

endpackage

// File: rtl/rx_tile_scheduler_if.sv
// Tile-in / tile-RAM-write / accelerator handshake bundle for rx_tile_scheduler.
interface rx_tile_scheduler_if #(
  parameter int TILE_W = 288,
  parameter int ADDR_W = 4
);
  logic              tile_vld;
  logic [TILE_W-1:0] tile_data;
  logic              mem_we;
  logic              mem_bank;
  logic [ADDR_W-1:0] mem_addr;
  logic [TILE_W-1:0] mem_wdata;
  logic              acc_start;
  logic              acc_bank;
  logic              acc_done;
  logic              acc_busy;
  logic [15:0]       frame_cnt;
  logic              ovf_err;
  logic              clr_err;

  modport master (
    output tile_vld, tile_data, acc_done, clr_err,
    input  mem_we, mem_bank, mem_addr, mem_wdata,
    input  acc_start, acc_bank, acc_busy, frame_cnt, ovf_err
  );

  modport slave (
    input  tile_vld, tile_data, acc_done, clr_err,
    output mem_we, mem_bank, mem_addr, mem_wdata,
    output acc_start, acc_bank, acc_busy, frame_cnt, ovf_err
  );
endinterface

// File: rtl/rx_tile_scheduler_tile_bank_ctrl.sv
// Lifecycle of one ping-pong bank: FREE -> FILLING -> READY -> COMPUTING -> FREE.
module tile_bank_ctrl
  import rx_tile_scheduler_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic fill_i,
  input  logic last_i,
  input  logic launch_i,
  input  logic done_i,
  output logic writable_o,
  output logic ready_o
);

  bank_state_e state_q, state_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= BANK_FREE;
    else       state_q <= state_d;
  end

  // fill, launch and done are only raised in mutually exclusive states
  always_comb begin
    state_d = state_q;
    case (state_q)
      BANK_FREE:      if (fill_i) state_d = last_i ? BANK_READY : BANK_FILLING;
      BANK_FILLING:   if (fill_i && last_i) state_d = BANK_READY;
      BANK_READY:     if (launch_i) state_d = BANK_COMPUTING;
      BANK_COMPUTING: if (done_i) state_d = BANK_FREE;
      default:        state_d = BANK_FREE;
    endcase
  end

  assign writable_o = bank_is_writable(state_q);
  assign ready_o    = (state_q == BANK_READY);

endmodule

// File: rtl/rx_tile_scheduler.sv
// Ping-pong tile buffer scheduler: writes tiles into two banks and launches the
// accelerator on each complete frame, in arrival order.
module rx_tile_scheduler
  import rx_tile_scheduler_pkg::*;
#(
  parameter int TILE_W          = TILE_W_DEF,
  parameter int TILES_PER_FRAME = 16,
  parameter int ADDR_W          = 4
) (
  input  logic                clk,
  input  logic                rstn,
  rx_tile_scheduler_if.slave  bus
);

  logic                   wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0]      idx_q, idx_d;
  logic                   rd_bank_q, rd_bank_d;
  lnc_state_e             lnc_q, lnc_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   ovf_q, ovf_d;

  logic                   mem_we_q;
  logic                   mem_bank_q;
  logic [ADDR_W-1:0]      mem_addr_q;
  logic [TILE_W-1:0]      mem_wdata_q;

  logic [1:0] bank_writable, bank_ready, bank_fill, bank_launch, bank_done;
  logic       accept, drop, last_tile, launch, done;

  // bank state is sampled before this cycle's done, so a tile racing acc_done is dropped
  assign accept    = bus.tile_vld &&  bank_writable[wr_bank_q];
  assign drop      = bus.tile_vld && !bank_writable[wr_bank_q];
  assign last_tile = (idx_q == ADDR_W'(TILES_PER_FRAME - 1));
  assign launch    = (lnc_q == LNC_START);
  assign done      = (lnc_q == LNC_WAIT) && bus.acc_done;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_fill[b]   = accept && (wr_bank_q == 1'(b));
    assign bank_launch[b] = launch && (rd_bank_q == 1'(b));
    assign bank_done[b]   = done   && (rd_bank_q == 1'(b));

    tile_bank_ctrl u_bank (
      .clk        (clk),
      .rstn       (rstn),
      .fill_i     (bank_fill[b]),
      .last_i     (last_tile),
      .launch_i   (bank_launch[b]),
      .done_i     (bank_done[b]),
      .writable_o (bank_writable[b]),
      .ready_o    (bank_ready[b])
    );
  end

  always_comb begin
    wr_bank_d = wr_bank_q;
    idx_d     = idx_q;
    if (accept) begin
      if (last_tile) begin
        idx_d     = '0;
        wr_bank_d = ~wr_bank_q;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (drop)             ovf_d = 1'b1;
    else if (bus.clr_err) ovf_d = 1'b0;
  end

  // Strict bank alternation keeps launches in frame arrival order
  always_comb begin
    lnc_d       = lnc_q;
    rd_bank_d   = rd_bank_q;
    frame_cnt_d = frame_cnt_q;
    case (lnc_q)
      LNC_IDLE:  if (bank_ready[rd_bank_q]) lnc_d = LNC_START;
      LNC_START: begin
        lnc_d       = LNC_WAIT;
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
      LNC_WAIT:  if (bus.acc_done) begin
        lnc_d     = LNC_IDLE;
        rd_bank_d = ~rd_bank_q;
      end
      default:   lnc_d = LNC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_bank_q   <= 1'b0;
      idx_q       <= '0;
      rd_bank_q   <= 1'b0;
      lnc_q       <= LNC_IDLE;
      frame_cnt_q <= '0;
      ovf_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_bank_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      idx_q       <= idx_d;
      rd_bank_q   <= rd_bank_d;
      lnc_q       <= lnc_d;
      frame_cnt_q <= frame_cnt_d;
      ovf_q       <= ovf_d;
      mem_we_q    <= accept;
      if (accept) begin
        mem_bank_q  <= wr_bank_q;
        mem_addr_q  <= idx_q;
        mem_wdata_q <= bus.tile_data;
      end
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_bank  = mem_bank_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.acc_start = (lnc_q == LNC_START);
  assign bus.acc_bank  = rd_bank_q;
  assign bus.acc_busy  = (lnc_q != LNC_IDLE);
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.ovf_err   = ovf_q;

endmodule

// File: tb/tb_rx_tile_scheduler.sv
// Bench for rx_tile_scheduler: directed scenarios plus random traffic against a frame-level model.
module tb_rx_tile_scheduler;

  localparam int TILE_W = 288;
  localparam int TPF    = 16;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  rx_tile_scheduler_if #(.TILE_W(TILE_W), .ADDR_W(ADDR_W)) bus ();

  rx_tile_scheduler #(.TILE_W(TILE_W), .TILES_PER_FRAME(TPF), .ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Frame-level model: tiles land in the current fill bank until it holds a frame;
  // complete frames queue up and launch in order once the accelerator is free.
  int                m_idx;
  bit                m_wb;
  bit                m_full [2];
  int                rq_bank [$];
  int                rq_time [$];
  bit                m_busy;
  bit                m_acc_bank;
  int                m_allow;
  logic [15:0]       m_frames;
  bit                m_ovf;
  bit                exp_we;
  bit                exp_bank;
  int                exp_addr;
  logic [TILE_W-1:0] exp_data;

  task automatic chk_val(input string tag, input logic [TILE_W-1:0] obs, input logic [TILE_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_idx = 0; m_wb = 0; m_full[0] = 0; m_full[1] = 0;
    rq_bank.delete(); rq_time.delete();
    m_busy = 0; m_acc_bank = 0; m_allow = 0; m_frames = '0; m_ovf = 0;
    exp_we = 0; exp_bank = 0; exp_addr = 0; exp_data = '0;
  endtask

  task automatic do_reset();
    bus.tile_vld = 0; bus.tile_data = '0; bus.acc_done = 0; bus.clr_err = 0;
    rstn = 0;
    #3;
    chk_val("rst_mem_we",    bus.mem_we,    0);
    chk_val("rst_mem_bank",  bus.mem_bank,  0);
    chk_val("rst_mem_addr",  bus.mem_addr,  0);
    chk_val("rst_mem_wdata", bus.mem_wdata, 0);
    chk_val("rst_acc_start", bus.acc_start, 0);
    chk_val("rst_acc_bank",  bus.acc_bank,  0);
    chk_val("rst_acc_busy",  bus.acc_busy,  0);
    chk_val("rst_frame_cnt", bus.frame_cnt, 0);
    chk_val("rst_ovf_err",   bus.ovf_err,   0);
    @(posedge clk); #1;
    rstn = 1;
    model_clear();
  endtask

  // One clock cycle: check outputs against the model, drive inputs, advance the model.
  task automatic step(input bit vld, input bit done, input bit clr);
    logic [TILE_W-1:0] data;
    bit start_now;
    bit drop;
    start_now = 0;
    if (!m_busy && rq_bank.size() > 0 && cyc >= m_allow) begin
      if (rq_time[0] <= cyc) start_now = 1;
    end
    if (start_now) begin
      m_busy     = 1;
      m_acc_bank = rq_bank[0][0];
      rq_bank.delete(0);
      rq_time.delete(0);
    end

    chk_val("mem_we", bus.mem_we, exp_we);
    if (exp_we) begin
      chk_val("mem_bank",  bus.mem_bank,  exp_bank);
      chk_val("mem_addr",  bus.mem_addr,  exp_addr[ADDR_W-1:0]);
      chk_val("mem_wdata", bus.mem_wdata, exp_data);
    end
    chk_val("acc_start", bus.acc_start, start_now);
    chk_val("acc_busy",  bus.acc_busy,  m_busy);
    if (m_busy) chk_val("acc_bank", bus.acc_bank, m_acc_bank);
    chk_val("frame_cnt", bus.frame_cnt, m_frames);
    chk_val("ovf_err",   bus.ovf_err,   m_ovf);
    if (start_now) m_frames = m_frames + 16'd1;

    for (int i = 0; i < TILE_W / 32; i++) data[i*32 +: 32] = $urandom();
    bus.tile_vld  = vld;
    bus.tile_data = data;
    bus.acc_done  = done;
    bus.clr_err   = clr;

    exp_we = 0;
    drop   = 0;
    if (vld) begin
      if (m_full[m_wb]) begin
        drop = 1;
      end else begin
        exp_we   = 1;
        exp_bank = m_wb;
        exp_addr = m_idx;
        exp_data = data;
        m_idx++;
        if (m_idx == TPF) begin
          m_full[m_wb] = 1;
          rq_bank.push_back(int'(m_wb));
          rq_time.push_back(cyc + 2);
          m_wb  = ~m_wb;
          m_idx = 0;
        end
      end
    end
    if (drop)     m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (done && m_busy && !start_now) begin
      m_full[m_acc_bank] = 0;
      m_busy  = 0;
      m_allow = cyc + 2;
    end

    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic send_tiles(input int n, input int gap);
    for (int t = 0; t < n; t++) begin
      step(1, 0, 0);
      for (int g = 1; g < gap; g++) step(0, 0, 0);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0);
  endtask

  initial begin
    rstn = 0;
    bus.tile_vld = 0; bus.tile_data = '0; bus.acc_done = 0; bus.clr_err = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // One frame at a slow rate into bank 0
    send_tiles(TPF, 10);
    chk_val("first_frame_cnt", bus.frame_cnt, 1);
    chk_val("first_acc_bank",  bus.acc_bank,  0);

    // Accelerator held busy: bank 1 fills, remaining tiles overflow
    send_tiles(2 * TPF, 2);
    idle(4);
    chk_val("ovf_after_both_full", bus.ovf_err, 1);
    step(0, 1, 0);
    idle(3);
    chk_val("second_frame_cnt", bus.frame_cnt, 2);
    chk_val("second_acc_bank",  bus.acc_bank,  1);
    step(0, 0, 1);
    idle(1);
    chk_val("ovf_cleared", bus.ovf_err, 0);

    // Refill bank 0, then overflow and clear together
    send_tiles(TPF, 1);
    step(1, 0, 1);
    idle(1);
    chk_val("ovf_set_wins", bus.ovf_err, 1);

    // Drain both banks, then a stray done while idle
    step(0, 1, 0);
    idle(4);
    step(0, 1, 0);
    idle(4);
    step(0, 1, 0);
    idle(4);
    chk_val("idle_done_frames", bus.frame_cnt, 3);
    chk_val("idle_done_busy",   bus.acc_busy,  0);

    // Reset mid-frame discards the partial frame
    send_tiles(7, 1);
    do_reset();
    send_tiles(TPF, 1);
    idle(4);
    chk_val("post_reset_frames", bus.frame_cnt, 1);
    chk_val("post_reset_bank",   bus.acc_bank,  0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      step($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 4);
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
